alu_writeback_regfile: RTL
==========================

// Module: alu_writeback_regfile
// PURPOSE
//  Downstream consumer of the 8-bit ripple add/sub stage. Accepts {sum, overflow} results
//  through a valid/ready handshake, commits them to a 4x8 register file and updates
//  Z/N/V/sticky-V flags. Two combinational read ports supply the next a/b operands.
//  A one-entry hold buffer absorbs a result that arrives while the file is stalled.
// PARAMETERS
//  DATA_W    8   result and register width
//  NUM_REGS  4   register-file depth
//  ADDR_W    2   register address width, equal to clog2(NUM_REGS)
// PORTS
//  clk          in   1       single clock; all state updates on its rising edge
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       result beat present
//  in_ready     out  1       block can accept a beat this cycle
//  in_sum       in   DATA_W  adder sum
//  in_overflow  in   1       adder signed overflow
//  in_dest      in   ADDR_W  destination register
//  in_wen       in   1       1 = write register and flags; 0 = flags only (compare)
//  stall        in   1       freeze commits; a beat accepted during stall is held
//  clr_sticky   in   1       clear flag_v_sticky
//  rd_addr_a    in   ADDR_W  read port A address
//  rd_data_a    out  DATA_W  read port A data, combinational from the register array
//  rd_addr_b    in   ADDR_W  read port B address
//  rd_data_b    out  DATA_W  read port B data, combinational from the register array
//  flag_z       out  1       last committed sum == 0
//  flag_n       out  1       last committed sum[DATA_W-1]
//  flag_v       out  1       last committed overflow
//  flag_v_sticky out 1       OR of all overflows since reset or clear
//  wb_count     out  8       committed-beat counter, saturates at 255
// BEHAVIOUR
//  - Reset: all registers 0; all flags 0; wb_count 0; FSM in PASS; hold buffer empty.
//    The result of a read during reset is 0. A held beat is discarded.
//  - Handshake: a beat transfers when in_valid && in_ready at a clock edge.
//    in_ready = (state == PASS). in_ready does not depend on in_valid.
//  - FSM PASS:
//    - transfer && !stall: commit at this edge.
//    - transfer && stall: capture the beat in the hold buffer and move to HOLD.
//  - FSM HOLD: in_ready = 0. When stall is low, commit the held beat at that edge and
//    return to PASS. The block does not accept a new beat in the same cycle.
//  - Commit:
//    - If in_wen, regs[dest] <= sum.
//    - flag_z/n/v update from sum and overflow.
//    - sticky <= sticky | overflow.
//    - wb_count increments, saturating at 255.
//    Latency: registers and flags are visible one cycle after the accepting or releasing edge.
//  - Reads return the stored value. There is no bypass of a same-edge write.
//  - clr_sticky and an overflow commit at the same edge: sticky = 1 (set wins).
//  - stall with in_valid low leaves state unchanged. Flags hold between commits.
//  - Sums are taken as delivered. This block performs no arithmetic apart from the zero test.
// STRUCTURE
//  - Shared package: DATA_W/ADDR_W constants, FSM state enum {PASS, HOLD},
//    flags struct {z, n, v, v_sticky}.
//  - One sub-module: regfile_2r1w, the array with a synchronous write port, two async read
//    ports and synchronous clear. The hold buffer, FSM, flags and counter stay in the top.
// TESTING
//  - 1+1, op=0 (sum=0x02, ovf=0), dest=1, wen=1, stall=0 -> next cycle: reg1=0x02,
//    Z=0, N=0, V=0, wb_count=1.
//  - 1-1 (sum=0x00), dest=2 -> reg2=0x00, Z=1. Read A=1, B=2 -> 0x02, 0x00.
//  - sum=0x80, ovf=1 (127+1) -> N=1, V=1, sticky=1. Then sum=0x05, ovf=0 -> V=0 and
//    sticky=1. Then clr_sticky -> sticky=0.
//  - stall=1 with beat 0x11->r3 -> in_ready=0 the next cycle and r3 unchanged. Beat 0x22
//    waits. Drop stall -> r3=0x11, then 0x22 commits next, in order, with no loss.
//  - Assert rst while in HOLD -> next cycle: in_ready=1, all registers, flags and
//    wb_count are 0, and the held beat is never written.
//  - clr_sticky=1 on the same edge as an ovf=1 commit -> sticky=1. wen=0 beat -> flags
//    update and the register is unchanged. 256 commits -> wb_count stays 255.

Source files
------------

// File: rtl/alu_writeback_regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_writeback_regfile_pkg : shared widths, FSM state and flag types        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_writeback_regfile_pkg;

  localparam int C_DATA_W   = 8;
  localparam int C_NUM_REGS = 4;
  localparam int C_ADDR_W   = 2;

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic v_sticky;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_writeback_regfile_regfile_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_2r1w : register array, one synchronous write, two async reads      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_2r1w #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads are forced to zero while reset is asserted, before the clear lands.
  assign o_rdata_a = rst ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = rst ? '0 : r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_writeback_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_writeback_regfile : commits adder results to a 4x8 file, tracks flags  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_writeback_regfile
  import alu_writeback_regfile_pkg::*;
#(
  parameter int DATA_W   = C_DATA_W,
  parameter int NUM_REGS = C_NUM_REGS,
  parameter int ADDR_W   = C_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_overflow,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wen,
  input  logic              stall,
  input  logic              clr_sticky,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              flag_v_sticky,
  output logic [7:0]        wb_count
);

  state_e            r_state;
  logic [DATA_W-1:0] r_hold_sum;
  logic              r_hold_ovf;
  logic [ADDR_W-1:0] r_hold_dest;
  logic              r_hold_wen;
  flags_t            r_flags;
  logic [7:0]        r_wb_count;

  logic              w_accept;
  logic              w_commit;
  logic              w_from_hold;
  logic [DATA_W-1:0] w_c_sum;
  logic              w_c_ovf;
  logic [ADDR_W-1:0] w_c_dest;
  logic              w_c_wen;

  assign in_ready    = (r_state == ST_PASS);
  assign w_accept    = in_valid & in_ready;
  assign w_from_hold = (r_state == ST_HOLD);
  assign w_commit    = w_from_hold ? ~stall : (w_accept & ~stall);

  assign w_c_sum  = w_from_hold ? r_hold_sum  : in_sum;
  assign w_c_ovf  = w_from_hold ? r_hold_ovf  : in_overflow;
  assign w_c_dest = w_from_hold ? r_hold_dest : in_dest;
  assign w_c_wen  = w_from_hold ? r_hold_wen  : in_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PASS;
      r_hold_sum  <= '0;
      r_hold_ovf  <= 1'b0;
      r_hold_dest <= '0;
      r_hold_wen  <= 1'b0;
      r_flags     <= '0;
      r_wb_count  <= '0;
    end else begin
      case (r_state)
        ST_PASS: begin
          if (w_accept && stall) begin
            r_hold_sum  <= in_sum;
            r_hold_ovf  <= in_overflow;
            r_hold_dest <= in_dest;
            r_hold_wen  <= in_wen;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) r_state <= ST_PASS;
        end
        default: r_state <= ST_PASS;
      endcase

      if (w_commit) begin
        r_flags.z <= (w_c_sum == '0);
        r_flags.n <= w_c_sum[DATA_W-1];
        r_flags.v <= w_c_ovf;
        if (r_wb_count != 8'hFF) r_wb_count <= r_wb_count + 8'd1;
      end
      // A committing overflow beats a simultaneous clear.
      r_flags.v_sticky <= (r_flags.v_sticky & ~clr_sticky) | (w_commit & w_c_ovf);
    end
  end

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_commit & w_c_wen),
    .i_waddr  (w_c_dest),
    .i_wdata  (w_c_sum),
    .i_raddr_a(rd_addr_a),
    .o_rdata_a(rd_data_a),
    .i_raddr_b(rd_addr_b),
    .o_rdata_b(rd_data_b)
  );

  assign flag_z        = r_flags.z;
  assign flag_n        = r_flags.n;
  assign flag_v        = r_flags.v;
  assign flag_v_sticky = r_flags.v_sticky;
  assign wb_count      = r_wb_count;

endmodule
`default_nettype wire
